// File: rtl/nios_system_led_seq_pkg.sv
// +----------------------------------------------------------------------+
// | nios_system_led_seq_pkg : register map, bit indices and FSM states   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package nios_system_led_seq_pkg;

  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_PERIOD   = 3'd1;
  localparam logic [2:0] REG_LENGTH   = 3'd2;
  localparam logic [2:0] REG_STATUS   = 3'd3;
  localparam logic [2:0] REG_TAB_IDX  = 3'd4;
  localparam logic [2:0] REG_TAB_DATA = 3'd5;

  localparam int CTRL_RUN     = 0;
  localparam int CTRL_ONESHOT = 1;
  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_IDX_LSB = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    WAIT  = 2'd2,
    BLANK = 2'd3
  } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/nios_system_led_seq_table.sv
// +----------------------------------------------------------------------+
// | nios_system_led_seq_table : pattern register file, 1W / 2R (comb)    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module nios_system_led_seq_table #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] cpu_raddr,
  output logic [DATA_W-1:0]        cpu_rdata,
  input  logic [$clog2(DEPTH)-1:0] seq_raddr,
  output logic [DATA_W-1:0]        seq_rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign cpu_rdata = mem[cpu_raddr];
  assign seq_rdata = mem[seq_raddr];

endmodule

`default_nettype wire

// File: rtl/nios_system_led_sequencer.sv
// +----------------------------------------------------------------------+
// | nios_system_led_sequencer : autonomous LED PIO pattern sequencer     |
// | Option macro LED_SEQ_BLANK_ON_STOP_EN: write 0 to the PIO on stop.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module nios_system_led_sequencer
  import nios_system_led_seq_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 8,
  parameter int PERIOD_W = 24
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [1:0]  pio_address,
  output logic        pio_chipselect,
  output logic        pio_write_n,
  output logic [31:0] pio_writedata,
  output logic        busy
);

  localparam int IW = $clog2(DEPTH);
  localparam int LW = IW + 1;
`ifdef LED_SEQ_BLANK_ON_STOP_EN
  localparam bit BLANK_ON_STOP = 1'b1;
`else
  localparam bit BLANK_ON_STOP = 1'b0;
`endif
  localparam seq_state_t STOP_STATE = BLANK_ON_STOP ? BLANK : IDLE;

  seq_state_t          state;
  logic                run, oneshot, done;
  logic [PERIOD_W-1:0] period, cnt, period_m1;
  logic [LW-1:0]       length, length_eff;
  logic [IW-1:0]       tab_idx, idx, next_idx, seq_raddr;
  logic [DATA_W-1:0]   pattern, cpu_rdata, seq_rdata;
  logic                cpu_wr, tab_we, last, go_stop;

  assign cpu_wr = chipselect & ~write_n;
  assign tab_we = cpu_wr && (address == REG_TAB_DATA);

  always_comb begin
    length_eff = length;
    if (length == '0)              length_eff = LW'(1);
    else if (length > LW'(DEPTH))  length_eff = LW'(DEPTH);
  end

  assign period_m1 = (period == '0) ? '0 : period - PERIOD_W'(1);
  assign last      = ({1'b0, idx} == length_eff - LW'(1));
  assign next_idx  = last ? '0 : idx + IW'(1);
  // In WAIT the table is read at the index the upcoming WRITE will use
  assign seq_raddr = (state == WAIT) ? next_idx : '0;
  assign go_stop   = ((state == WRITE) && !run) ||
                     ((state == WAIT) && (!run || ((cnt == '0) && last && oneshot)));

  nios_system_led_seq_table #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_table (
    .clk       (clk),
    .reset_n   (reset_n),
    .we        (tab_we),
    .waddr     (tab_idx),
    .wdata     (writedata[DATA_W-1:0]),
    .cpu_raddr (tab_idx),
    .cpu_rdata (cpu_rdata),
    .seq_raddr (seq_raddr),
    .seq_rdata (seq_rdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      run            <= 1'b0;
      oneshot        <= 1'b0;
      done           <= 1'b0;
      period         <= '0;
      length         <= '0;
      tab_idx        <= '0;
      idx            <= '0;
      cnt            <= '0;
      pattern        <= '0;
      pio_chipselect <= 1'b0;
      pio_write_n    <= 1'b1;
    end else begin
      if (cpu_wr) begin
        case (address)
          REG_CTRL: begin
            run     <= writedata[CTRL_RUN];
            oneshot <= writedata[CTRL_ONESHOT];
          end
          REG_PERIOD:   period  <= writedata[PERIOD_W-1:0];
          REG_LENGTH:   length  <= (writedata > 32'(DEPTH)) ? LW'(DEPTH) : writedata[LW-1:0];
          REG_STATUS:   if (writedata[STAT_DONE]) done <= 1'b0;
          REG_TAB_IDX:  tab_idx <= writedata[IW-1:0];
          REG_TAB_DATA: tab_idx <= tab_idx + IW'(1);
          default: ;
        endcase
      end

      pio_chipselect <= 1'b0;
      pio_write_n    <= 1'b1;

      // FSM updates follow the CPU writes so a completing oneshot wins over a DONE clear
      if (go_stop) begin
        state <= STOP_STATE;
        if ((state == WAIT) && run) begin
          done <= 1'b1;
          run  <= 1'b0;
        end
        if (BLANK_ON_STOP) begin
          pattern        <= '0;
          pio_chipselect <= 1'b1;
          pio_write_n    <= 1'b0;
        end
      end else begin
        case (state)
          IDLE: if (run) begin
            idx            <= '0;
            pattern        <= seq_rdata;
            pio_chipselect <= 1'b1;
            pio_write_n    <= 1'b0;
            state          <= WRITE;
          end
          WRITE: begin
            cnt   <= period_m1;
            state <= WAIT;
          end
          WAIT: if (cnt != '0) begin
            cnt <= cnt - PERIOD_W'(1);
          end else begin
            idx            <= next_idx;
            pattern        <= seq_rdata;
            pio_chipselect <= 1'b1;
            pio_write_n    <= 1'b0;
            state          <= WRITE;
          end
          BLANK:   state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      REG_CTRL: begin
        readdata[CTRL_RUN]     = run;
        readdata[CTRL_ONESHOT] = oneshot;
      end
      REG_PERIOD:   readdata[PERIOD_W-1:0] = period;
      REG_LENGTH:   readdata[LW-1:0]       = length;
      REG_STATUS: begin
        readdata[STAT_BUSY]             = busy;
        readdata[STAT_DONE]             = done;
        readdata[STAT_IDX_LSB +: IW]    = idx;
      end
      REG_TAB_IDX:  readdata[IW-1:0]     = tab_idx;
      REG_TAB_DATA: readdata[DATA_W-1:0] = cpu_rdata;
      default: ;
    endcase
  end

  assign pio_address   = 2'b00;
  assign pio_writedata = {{(32-DATA_W){1'b0}}, pattern};
  assign busy          = (state != IDLE);

endmodule

`default_nettype wire
